// File: rtl/nand_bist_if.sv
// nand_bist_if: signal bundle between the NAND BIST sequencer and the
// controller/project side. The slave modport is the BIST. The master modport
// is whoever drives start/ena and returns the project response.
interface nand_bist_if;
  logic       ena;
  logic       start;
  logic [7:0] dut_ui;
  logic [7:0] dut_uo;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_cnt;
  logic [7:0] fail_vec;

  modport master (
    output ena, start, dut_uo,
    input  dut_ui, busy, done, pass, err_cnt, fail_vec
  );

  modport slave (
    input  ena, start, dut_uo,
    output dut_ui, busy, done, pass, err_cnt, fail_vec
  );
endinterface

// File: rtl/nand_bist.sv
// nand_bist: exhaustive self-test sequencer for the NAND user project.
// It sweeps all 256 input vectors. For each vector it waits SETTLE idle cycles,
// then compares the masked response against the golden NAND function.
// Optional build macro NAND_BIST_STOP_ON_FAIL_EN ends the sweep at the first
// mismatching vector. When the macro is undefined, all 256 vectors always run.
module nand_bist #(
  parameter int unsigned SETTLE = 2,       // legal range 1..15
  parameter logic [7:0]  MASK   = 8'h0F    // 0 bits are don't-care
) (
  input logic        clk,
  input logic        rst_n,
  nand_bist_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  // The settle counter counts down to zero, so the SETTLE state lasts exactly SETTLE cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [7:0] vec_q, vec_d;
  logic [3:0] settle_q, settle_d;
  logic [7:0] ui_q, ui_d;
  logic [7:0] err_q, err_d;
  logic [7:0] fail_q, fail_d;
  logic       seen_q, seen_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [7:0] exp_w;
  logic       mismatch_w;

  // Golden response for the current vector and the masked compare. Only registers see this result.
  always_comb begin
    exp_w      = {4'h0, ~(vec_q[3:0] & vec_q[7:4])};
    mismatch_w = |((bus.dut_uo ^ exp_w) & MASK);
  end

  // Next-state logic for the sweep FSM, the counters and the registered status flags.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    ui_d     = ui_q;
    err_d    = err_q;
    fail_d   = fail_q;
    seen_d   = seen_q;
    pass_d   = pass_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_DRIVE;
          vec_d   = 8'h00;
          err_d   = 8'h00;
          fail_d  = 8'h00;
          seen_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end

      S_DRIVE: begin
        ui_d     = vec_q;
        settle_d = SETTLE_LOAD;
        state_d  = S_SETTLE;
      end

      S_SETTLE: begin
        if (settle_q == 4'd0) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end

      S_CHECK: begin
        if (mismatch_w) begin
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
          if (!seen_q) begin
            seen_d = 1'b1;
            fail_d = vec_q;
          end
        end
`ifdef NAND_BIST_STOP_ON_FAIL_EN
        if (mismatch_w || (vec_q == 8'hFF)) begin
`else
        if (vec_q == 8'hFF) begin
`endif
          state_d = S_DONE;
          pass_d  = (err_d == 8'h00);
        end else begin
          vec_d   = vec_q + 8'd1;
          state_d = S_DRIVE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_DRIVE) || (state_d == S_SETTLE) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  // State and result registers. They reset asynchronously, and ena low freezes all of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      vec_q    <= 8'h00;
      settle_q <= 4'd0;
      ui_q     <= 8'h00;
      err_q    <= 8'h00;
      fail_q   <= 8'h00;
      seen_q   <= 1'b0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.ena) begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      ui_q     <= ui_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      seen_q   <= seen_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.dut_ui   = ui_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_cnt  = err_q;
  assign bus.fail_vec = fail_q;

endmodule

// File: tb/tb_nand_bist.sv
// tb_nand_bist: directed bench for nand_bist. Instance A uses MASK=8'h0F and
// instance B uses MASK=8'hFF. Both instances face the same emulated NAND project,
// and that project can have a stuck output bit injected.
module tb_nand_bist;

`ifdef NAND_BIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic start;
  int   faultMode;
  int   checkCount = 0;
  int   passCount  = 0;

  nand_bist_if busA();
  nand_bist_if busB();

  // Emulated project: 4x NAND on ui_in nibbles; fault 1 sticks uo[0] high, fault 2 sticks uo[7] high
  function automatic logic [7:0] projectModel(input logic [7:0] v, input int fm);
    logic [7:0] r;
    r = {4'h0, ~(v[3:0] & v[7:4])};
    if (fm == 1) r[0] = 1'b1;
    if (fm == 2) r[7] = 1'b1;
    return r;
  endfunction

  assign busA.ena    = ena;
  assign busA.start  = start;
  assign busA.dut_uo = projectModel(busA.dut_ui, faultMode);
  assign busB.ena    = ena;
  assign busB.start  = start;
  assign busB.dut_uo = projectModel(busB.dut_ui, faultMode);

  nand_bist #(.SETTLE(2), .MASK(8'h0F)) u_dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
  );

  nand_bist #(.SETTLE(2), .MASK(8'hFF)) u_dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse start, then count cycles until A reports done. Optionally drop ena for 10 cycles, or re-pulse start while busy.
  task automatic applyStimulus(input int pauseAt, input int startAt, output int cycles);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    checkOutput("busyInDrive", 32'(busA.busy), 32'd1);
    while (busA.done !== 1'b1 && cycles < 4000) begin
      if (cycles == pauseAt) ena = 1'b0;
      if (pauseAt >= 0 && cycles == pauseAt + 10) ena = 1'b1;
      if (cycles == startAt) start = 1'b1;
      if (startAt >= 0 && cycles == startAt + 1) start = 1'b0;
      @(negedge clk);
      cycles++;
    end
    ena   = 1'b1;
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    rst_n     = 1'b0;
    ena       = 1'b1;
    start     = 1'b0;
    faultMode = 0;
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rstDutUi",   32'(busA.dut_ui),   32'h00);
    checkOutput("rstBusy",    32'(busA.busy),     32'd0);
    checkOutput("rstDone",    32'(busA.done),     32'd0);
    checkOutput("rstPass",    32'(busA.pass),     32'd0);
    checkOutput("rstErrCnt",  32'(busA.err_cnt),  32'h00);
    checkOutput("rstFailVec", 32'(busA.fail_vec), 32'h00);

    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("idleNoStart", 32'({busA.busy, busA.done}), 32'd0);

    $display("[TB] clean sweep");
    applyStimulus(-1, -1, cycles);
    checkOutput("cleanLen",   32'(cycles),        32'd1024);
    checkOutput("cleanPass",  32'(busA.pass),     32'd1);
    checkOutput("cleanErr",   32'(busA.err_cnt),  32'h00);
    checkOutput("cleanFail",  32'(busA.fail_vec), 32'h00);
    checkOutput("cleanBusy",  32'(busA.busy),     32'd0);
    checkOutput("cleanPassB", 32'(busB.pass),     32'd1);

    $display("[TB] uo[0] stuck at 1");
    faultMode = 1;
    applyStimulus(-1, -1, cycles);
    checkOutput("s0Len",   32'(cycles),        STOP_ON_FAIL ? 32'd72 : 32'd1024);
    checkOutput("s0Err",   32'(busA.err_cnt),  STOP_ON_FAIL ? 32'd1 : 32'd64);
    checkOutput("s0Fail",  32'(busA.fail_vec), 32'h11);
    checkOutput("s0Pass",  32'(busA.pass),     32'd0);
    checkOutput("s0ErrB",  32'(busB.err_cnt),  STOP_ON_FAIL ? 32'd1 : 32'd64);
    checkOutput("s0FailB", 32'(busB.fail_vec), 32'h11);
    repeat (5) @(negedge clk);
    checkOutput("s0HoldDone", 32'(busA.done),    32'd1);
    checkOutput("s0HoldErr",  32'(busA.err_cnt), STOP_ON_FAIL ? 32'd1 : 32'd64);

    $display("[TB] uo[7] stuck at 1");
    faultMode = 2;
    applyStimulus(-1, -1, cycles);
    checkOutput("s7Len",   32'(cycles),        32'd1024);
    checkOutput("s7PassA", 32'(busA.pass),     32'd1);
    checkOutput("s7ErrA",  32'(busA.err_cnt),  32'h00);
    checkOutput("s7FailA", 32'(busA.fail_vec), 32'h00);
    checkOutput("s7ErrB",  32'(busB.err_cnt),  STOP_ON_FAIL ? 32'd1 : 32'd255);
    checkOutput("s7FailB", 32'(busB.fail_vec), 32'h00);
    checkOutput("s7PassB", 32'(busB.pass),     32'd0);
    checkOutput("s7DoneB", 32'(busB.done),     32'd1);

    $display("[TB] ena pause and start while busy");
    faultMode = 0;
    applyStimulus(300, 600, cycles);
    checkOutput("pauseLen",  32'(cycles),        32'd1034);
    checkOutput("pausePass", 32'(busA.pass),     32'd1);
    checkOutput("pauseErr",  32'(busA.err_cnt),  32'h00);
    checkOutput("pauseFail", 32'(busA.fail_vec), 32'h00);

    $display("[TB] reset mid-sweep at vector 0x80");
    faultMode = 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (busA.dut_ui !== 8'h80 && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("vec80Cycle", 32'(cycles), 32'd513);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arstDutUi", 32'(busA.dut_ui),  32'h00);
    checkOutput("arstBusy",  32'(busA.busy),    32'd0);
    checkOutput("arstDone",  32'(busA.done),    32'd0);
    checkOutput("arstErrB",  32'(busB.err_cnt), 32'h00);
    checkOutput("arstDoneB", 32'(busB.done),    32'd0);
    checkOutput("arstBusyB", 32'(busB.busy),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    faultMode = 0;
    applyStimulus(-1, -1, cycles);
    checkOutput("postRstLen",   32'(cycles),       32'd1024);
    checkOutput("postRstPass",  32'(busA.pass),    32'd1);
    checkOutput("postRstErr",   32'(busA.err_cnt), 32'h00);
    checkOutput("postRstPassB", 32'(busB.pass),    32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
